// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI path: arbiter state encoding, byte width
// and the requester slots used when wiring the init, clear and write engines.
package oled_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int MAX_REQ    = 8;

   localparam int REQ_INIT  = 0;
   localparam int REQ_CLEAR = 1;
   localparam int REQ_WRITE = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_SEND  = 2'd2,
      ST_WAIT  = 2'd3
   } arb_state_e;

   function automatic logic [2:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/oled_spi_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping to 0.
module rr_pick #(
   parameter int N_REQ = 3,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic             valid
);

   // First pass takes the lowest request above ptr; the second pass only
   // fires when none exists, so it yields the wrapped-around winner.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int j = 0; j < N_REQ; j++) begin
         if (!valid && req[j] && (j > int'(ptr))) begin
            grant[j] = 1'b1;
            valid    = 1'b1;
         end
      end
      for (int j = 0; j < N_REQ; j++) begin
         if (!valid && req[j]) begin
            grant[j] = 1'b1;
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/oled_spi_arbiter.sv
// Shares the spi_master byte channel between OLED requesters with round-robin
// grant, optional burst lock, per-byte ack and a watchdog on spi_send_done.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no owner; pick next requester after ptr
//   ST_GRANT | owner holds the bus, waiting for its byte_valid or req drop
//   ST_SEND  | spi_send pulse, watchdog armed
//   ST_WAIT  | byte on the wire, waiting for spi_send_done or watchdog expiry
module oled_spi_arbiter
   import oled_pkg::*;
#(
   parameter int N_REQ   = 3,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 65535
) (
   input  logic                    clkin_50m,
   input  logic                    sys_rst_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        lock,
   input  logic [N_REQ-1:0]        byte_valid,
   input  logic [N_REQ*DATA_W-1:0] byte_data,
   input  logic [N_REQ-1:0]        byte_dc,
   output logic [N_REQ-1:0]        grant,
   output logic [N_REQ-1:0]        byte_ack,
   output logic                    spi_send,
   output logic [DATA_W-1:0]       spi_data_out,
   output logic                    dc_out,
   input  logic                    spi_send_done,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   arb_state_e        state_q, state_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              dc_q, dc_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic              terr_q, terr_d;
   logic              busy_q, send_q;

   logic [N_REQ-1:0]  pick_grant;
   logic              pick_valid;
   logic              own_valid, own_req, own_lock, own_dc;
   logic [DATA_W-1:0] own_data;
   logic [IDX_W-1:0]  own_idx;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req   (req),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .valid (pick_valid)
   );

   assign own_valid = |(byte_valid & grant_q);
   assign own_req   = |(req & grant_q);
   assign own_lock  = |(lock & grant_q);
   assign own_idx   = IDX_W'(onehot_idx(MAX_REQ'(grant_q)));

   always_comb begin
      own_data = '0;
      own_dc   = 1'b0;
      for (int j = 0; j < N_REQ; j++) begin
         if (grant_q[j]) begin
            own_data = byte_data[j*DATA_W +: DATA_W];
            own_dc   = byte_dc[j];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      dc_d    = dc_q;
      wdog_d  = wdog_q;
      terr_d  = terr_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               grant_d = pick_grant;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (own_valid) begin
               data_d  = own_data;
               dc_d    = own_dc;
               state_d = ST_SEND;
            end else if (!own_req) begin
               grant_d = '0;
               ptr_d   = own_idx;
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            wdog_d  = WD_W'(TIMEOUT - 1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // done takes priority over a watchdog expiry in the same cycle
            if (spi_send_done) begin
               if (own_lock && own_req) begin
                  state_d = ST_GRANT;
               end else begin
                  grant_d = '0;
                  ptr_d   = own_idx;
                  state_d = ST_IDLE;
               end
            end else if (wdog_q == '0) begin
               terr_d  = 1'b1;
               grant_d = '0;
               ptr_d   = own_idx;
               state_d = ST_IDLE;
            end else begin
               wdog_d = wdog_q - WD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clkin_50m or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= IDX_W'(N_REQ - 1);
         data_q  <= '0;
         dc_q    <= 1'b0;
         wdog_q  <= '0;
         terr_q  <= 1'b0;
         busy_q  <= 1'b0;
         send_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         dc_q    <= dc_d;
         wdog_q  <= wdog_d;
         terr_q  <= terr_d;
         busy_q  <= (state_d != ST_IDLE);
         send_q  <= (state_d == ST_SEND);
      end
   end

   assign grant        = grant_q;
   assign byte_ack     = ((state_q == ST_WAIT) && spi_send_done) ? grant_q : '0;
   assign spi_send     = send_q;
   assign spi_data_out = data_q;
   assign dc_out       = dc_q;
   assign busy         = busy_q;
   assign timeout_err  = terr_q;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Scoreboard bench for oled_spi_arbiter: requester models feed byte queues,
// a monitor checks every spi_send and byte_ack against expected events.
module tb_oled_spi_arbiter;
   import oled_pkg::*;

   localparam int N   = 3;
   localparam int DW  = 8;
   localparam int TMO = 100;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0, lock = '0, byte_valid = '0, byte_dc = '0;
   logic [N*DW-1:0] byte_data = '0;
   logic [N-1:0]    grant, byte_ack;
   logic            spi_send, dc_out, busy, timeout_err;
   logic [DW-1:0]   spi_data_out;
   logic            spi_send_done = 1'b0;

   always #10 clk = ~clk;

   oled_spi_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clkin_50m     (clk),
      .sys_rst_n     (rst_n),
      .req           (req),
      .lock          (lock),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_dc       (byte_dc),
      .grant         (grant),
      .byte_ack      (byte_ack),
      .spi_send      (spi_send),
      .spi_data_out  (spi_data_out),
      .dc_out        (dc_out),
      .spi_send_done (spi_send_done),
      .busy          (busy),
      .timeout_err   (timeout_err)
   );

   typedef struct {
      bit         is_ack;
      logic [2:0] who;
      logic [7:0] data;
      logic       dc;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic       dc;
   } byte_t;

   exp_t         exp_q[$];
   byte_t        rq[N][$];
   logic [N-1:0] req_kill = '0;
   logic [N-1:0] ack_seen = '0;
   int           done_delay = 0;
   bit           prev_send = 1'b0;
   int           vectors = 0;
   int           miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic exp_send(input logic [2:0] who, input logic [7:0] d, input logic dc);
      exp_t e;
      e.is_ack = 1'b0; e.who = who; e.data = d; e.dc = dc;
      exp_q.push_back(e);
   endtask

   task automatic exp_ack(input logic [2:0] who);
      exp_t e;
      e.is_ack = 1'b1; e.who = who; e.data = '0; e.dc = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic load(input int i, input logic [7:0] d, input logic dc);
      byte_t b;
      b.data = d; b.dc = dc;
      rq[i].push_back(b);
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req[i]        = (rq[i].size() > 0) && !req_kill[i];
         byte_valid[i] = (rq[i].size() > 0) && !req_kill[i];
         byte_data[i*DW +: DW] = (rq[i].size() > 0) ? rq[i][0].data : 8'h00;
         byte_dc[i]    = (rq[i].size() > 0) ? rq[i][0].dc : 1'b0;
      end
   endtask

   task automatic wait_send(input string name);
      int n;
      n = 0;
      while (!spi_send && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, "_send_seen"}, spi_send, 1);
   endtask

   task automatic wait_ack(input string name);
      int n;
      n = 0;
      while (byte_ack == '0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, "_ack_seen"}, (byte_ack != '0), 1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || req != '0 || exp_q.size() != 0) && n < 2000);
      check({name, "_idle"}, busy, 0);
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   // Requester models: pop a byte after its ack, then present the next one.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (ack_seen[i] && rq[i].size() > 0) void'(rq[i].pop_front());
         end
         drive();
      end
   end

   // spi_master stand-in: done pulse done_delay cycles after spi_send.
   initial begin
      forever begin
         int d;
         @(negedge clk);
         d = done_delay;
         if (rst_n && spi_send && d > 0) begin
            repeat (d) @(posedge clk);
            #1 spi_send_done = 1'b1;
            @(posedge clk);
            #1 spi_send_done = 1'b0;
         end
      end
   end

   // Monitor
   initial begin
      forever begin
         exp_t e;
         @(negedge clk);
         ack_seen = byte_ack;
         if (rst_n) begin
            if (spi_send) begin
               check("send_single_pulse", prev_send, 0);
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_send: got grant=%b data=%h expected no send", grant, spi_data_out);
               end else begin
                  e = exp_q.pop_front();
                  check("send_kind", e.is_ack, 0);
                  check("send_grant", grant, e.who);
                  check("send_data", spi_data_out, e.data);
                  check("send_dc", dc_out, e.dc);
               end
            end
            if (byte_ack != '0) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_ack: got byte_ack=%b expected none", byte_ack);
               end else begin
                  e = exp_q.pop_front();
                  check("ack_kind", e.is_ack, 1);
                  check("ack_mask", byte_ack, e.who);
               end
            end
         end
         prev_send = spi_send;
      end
   end

   initial begin
      int   n;
      logic any_ack;

      repeat (3) @(posedge clk);
      #1;
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_send", spi_send, 0);
      check("rst_terr", timeout_err, 0);
      check("rst_data", spi_data_out, 0);
      check("rst_ack", byte_ack, 0);

      // Round robin: all three requesting, no lock
      @(negedge clk);
      rst_n = 1'b1;
      done_delay = 4;
      load(REQ_INIT, 8'h10, 1'b0);
      load(REQ_INIT, 8'h13, 1'b1);
      load(REQ_CLEAR, 8'h11, 1'b1);
      load(REQ_WRITE, 8'h12, 1'b0);
      exp_send(3'b001, 8'h10, 1'b0); exp_ack(3'b001);
      exp_send(3'b010, 8'h11, 1'b1); exp_ack(3'b010);
      exp_send(3'b100, 8'h12, 1'b0); exp_ack(3'b100);
      exp_send(3'b001, 8'h13, 1'b1); exp_ack(3'b001);
      wait_idle("rr");

      // Lock burst on requester 1 while requester 0 waits
      @(negedge clk);
      lock = 3'b010;
      load(1, 8'h21, 1'b0);
      load(1, 8'h00, 1'b1);
      load(1, 8'h7F, 1'b1);
      load(0, 8'h55, 1'b1);
      exp_send(3'b010, 8'h21, 1'b0); exp_ack(3'b010);
      exp_send(3'b010, 8'h00, 1'b1); exp_ack(3'b010);
      exp_send(3'b010, 8'h7F, 1'b1); exp_ack(3'b010);
      exp_send(3'b001, 8'h55, 1'b1); exp_ack(3'b001);
      wait_idle("lock");
      lock = '0;

      // Single request, done 20 cycles after spi_send
      @(negedge clk);
      done_delay = 20;
      load(0, 8'hAE, 1'b0);
      exp_send(3'b001, 8'hAE, 1'b0); exp_ack(3'b001);
      @(negedge clk);
      check("single_grant_before", grant, 3'b000);
      @(negedge clk);
      check("single_grant_latency", grant, 3'b001);
      check("single_busy", busy, 1);
      wait_ack("single");
      check("single_ack_on_done", spi_send_done, 1);
      @(negedge clk);
      check("single_grant_released", grant, 3'b000);
      check("single_busy_low", busy, 0);
      wait_idle("single");

      // Watchdog: no done, then the requester retries normally
      done_delay = 0;
      load(2, 8'h3C, 1'b0);
      exp_send(3'b100, 8'h3C, 1'b0);
      wait_send("tmo");
      n = 0;
      any_ack = 1'b0;
      do begin
         @(negedge clk);
         n++;
         any_ack = any_ack | (byte_ack != '0);
      end while (grant != '0 && n < 300);
      check("tmo_wait_cycles", n - 1, TMO);
      check("tmo_err_set", timeout_err, 1);
      check("tmo_no_ack", any_ack, 0);
      check("tmo_busy_low", busy, 0);
      done_delay = 5;
      exp_send(3'b100, 8'h3C, 1'b0); exp_ack(3'b100);
      wait_idle("tmo_retry");
      check("tmo_err_sticky", timeout_err, 1);

      // Stray done in IDLE
      @(negedge clk);
      spi_send_done = 1'b1;
      #1;
      check("stray_no_ack", byte_ack, 0);
      @(posedge clk);
      #1 spi_send_done = 1'b0;
      @(negedge clk);
      check("stray_busy", busy, 0);
      check("stray_grant", grant, 0);

      // req[2] drops the cycle after spi_send; byte must still complete
      lock = 3'b100;
      done_delay = 10;
      load(2, 8'h5A, 1'b1);
      exp_send(3'b100, 8'h5A, 1'b1); exp_ack(3'b100);
      wait_send("drop");
      req_kill[2] = 1'b1;
      @(negedge clk);
      wait_ack("drop");
      check("drop_ack_mask", byte_ack, 3'b100);
      check("drop_req_low", req[2], 0);
      @(negedge clk);
      check("drop_grant_clear", grant, 0);
      req_kill = '0;
      lock = '0;
      wait_idle("drop");

      // Asynchronous reset during WAIT
      done_delay = 0;
      load(1, 8'h11, 1'b0);
      exp_send(3'b010, 8'h11, 1'b0);
      wait_send("rstmid");
      repeat (5) @(negedge clk);
      check("rstmid_busy_before", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_grant", grant, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_data", spi_data_out, 0);
      check("rstmid_dc", dc_out, 0);
      check("rstmid_terr", timeout_err, 0);
      check("rstmid_ack", byte_ack, 0);
      rq[1].delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      done_delay = 3;
      load(2, 8'h77, 1'b1);
      load(0, 8'h66, 1'b0);
      exp_send(3'b001, 8'h66, 1'b0); exp_ack(3'b001);
      exp_send(3'b100, 8'h77, 1'b1); exp_ack(3'b100);
      wait_idle("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
